rabbit_frame_tx: RTL

Sends a byte range of a 184-bit (23-byte) frame back to the Rabbit microcontroller over the 8-bit parallel strobe/acknowledge bus. It is the transmit end of the Rabbit frame link, whose receive end delivers `whole184` to the hex-display converter. On a load request it snapshots the frame, checks the START/END byte range, and sends the selected bytes one per four-phase handshake. It can append an XOR checksum byte after the last data byte.

---
 rtl/rabbit_link_pkg.sv | 33 +++
 rtl/rabbit_frame_tx_ack_sync.sv | 21 ++
 rtl/rabbit_frame_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rabbit_link_pkg.sv
// Shared definitions for the Rabbit frame link: frame geometry, transmit FSM
// states and the byte-extraction helper used by both link ends.
package rabbit_link_pkg;

  localparam int         FRAME_BYTES  = 23;
  localparam int         FRAME_BITS   = 184;
  localparam logic [4:0] MAX_BYTE_IDX = 5'd22;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_HI,
    WAIT_LO,
    NEXT,
    FINISH
  } tx_state_e;

  // Byte k occupies frame bits 8k..8k+7 with bit 8k as the MSB.
  function automatic logic [7:0] frame_byte(input logic [0:FRAME_BITS-1] frame,
                                            input logic [4:0]            idx);
    logic [7:0] b;
    logic [7:0] base;
    b    = 8'h00;
    base = {idx, 3'b000};
    if (idx <= MAX_BYTE_IDX) begin
      for (int i = 0; i < 8; i++) begin
        b[3'(7 - i)] = frame[base + 8'(i)];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/rabbit_frame_tx_ack_sync.sv
// Two-flop synchronizer bringing the Rabbit ACK into the FITTYMEGA domain.
module ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/rabbit_frame_tx.sv
// Transmit end of the Rabbit frame link: snapshots a 23-byte frame and sends
// bytes START..END (plus optional XOR checksum) over the strobe/ack bus.
module rabbit_frame_tx
  import rabbit_link_pkg::*;
#(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit CHECKSUM_EN    = 1'b1
) (
  input  logic                  FITTYMEGA,
  input  logic                  RESET,
  input  logic [0:FRAME_BITS-1] WORD184,
  input  logic                  LOAD,
  input  logic [4:0]            START,
  input  logic [4:0]            END,
  input  logic                  ACK,
  output logic [7:0]            DATA,
  output logic                  STROBE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output tx_state_e             state_dbg
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Four-phase handshake: DATA is held SETUP_CYCLES, then STROBE rises; the
  // Rabbit raises ACK, STROBE falls, the Rabbit drops ACK, and only then may
  // DATA change for the next byte.
  tx_state_e             state, state_nxt;
  logic [0:FRAME_BITS-1] frame_q, frame_nxt;
  logic [4:0]            end_q, end_nxt, idx, idx_nxt;
  logic [7:0]            cks, cks_nxt, data_nxt;
  logic                  cks_sent, cks_sent_nxt;
  logic [SW-1:0]         set_cnt, set_cnt_nxt;
  logic [TW-1:0]         to_cnt, to_cnt_nxt;
  logic                  strobe_nxt, busy_nxt, done_nxt, err_nxt;
  logic                  ack_s, range_bad, setup_done, timeout, more_bytes;

  ack_sync u_ack_sync (
    .clk      (FITTYMEGA),
    .rst      (RESET),
    .async_in (ACK),
    .sync_out (ack_s)
  );

  assign range_bad  = (END < START) || (START > MAX_BYTE_IDX) || (END > MAX_BYTE_IDX);
  assign setup_done = (set_cnt == SW'(SETUP_CYCLES - 1));
  assign timeout    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign more_bytes = (idx < end_q) || (CHECKSUM_EN && !cks_sent);
  assign state_dbg  = state;

  always_ff @(posedge FITTYMEGA or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      frame_q  <= '0;
      end_q    <= '0;
      idx      <= '0;
      cks      <= '0;
      cks_sent <= 1'b0;
      set_cnt  <= '0;
      to_cnt   <= '0;
      DATA     <= 8'h00;
      STROBE   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame_q  <= frame_nxt;
      end_q    <= end_nxt;
      idx      <= idx_nxt;
      cks      <= cks_nxt;
      cks_sent <= cks_sent_nxt;
      set_cnt  <= set_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      DATA     <= data_nxt;
      STROBE   <= strobe_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      ERR      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (LOAD && !range_bad) state_nxt = SETUP;
      SETUP:   if (setup_done) state_nxt = WAIT_HI;
      WAIT_HI: if (ack_s) state_nxt = WAIT_LO;
               else if (timeout) state_nxt = IDLE;
      WAIT_LO: if (!ack_s) state_nxt = NEXT;
               else if (timeout) state_nxt = IDLE;
      NEXT:    state_nxt = more_bytes ? SETUP : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_nxt    = frame_q;
    end_nxt      = end_q;
    idx_nxt      = idx;
    cks_nxt      = cks;
    cks_sent_nxt = cks_sent;
    set_cnt_nxt  = set_cnt;
    to_cnt_nxt   = to_cnt;
    data_nxt     = DATA;
    strobe_nxt   = STROBE;
    busy_nxt     = BUSY;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (LOAD && range_bad) begin
          err_nxt = 1'b1;
        end else if (LOAD) begin
          frame_nxt    = WORD184;
          end_nxt      = END;
          idx_nxt      = START;
          cks_nxt      = 8'h00;
          cks_sent_nxt = 1'b0;
          set_cnt_nxt  = '0;
          busy_nxt     = 1'b1;
          data_nxt     = frame_byte(WORD184, START);
        end
      end
      SETUP: begin
        if (setup_done) begin
          strobe_nxt = 1'b1;
          to_cnt_nxt = '0;
        end else begin
          set_cnt_nxt = set_cnt + SW'(1);
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          strobe_nxt = 1'b0;
          cks_nxt    = cks ^ DATA;
          to_cnt_nxt = '0;
        end else if (timeout) begin
          strobe_nxt = 1'b0;
          err_nxt    = 1'b1;
          busy_nxt   = 1'b0;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      WAIT_LO: begin
        if (ack_s && timeout) begin
          err_nxt  = 1'b1;
          busy_nxt = 1'b0;
        end else if (ack_s) begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      NEXT: begin
        set_cnt_nxt = '0;
        if (idx < end_q) begin
          idx_nxt  = idx + 5'd1;
          data_nxt = frame_byte(frame_q, idx + 5'd1);
        end else if (CHECKSUM_EN && !cks_sent) begin
          data_nxt     = cks;
          cks_sent_nxt = 1'b1;
        end
      end
      FINISH: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
